// File: rtl/maxpool_pkg.sv
// maxpool_pkg: scheduler state encoding and element/map sizes shared with the pooling datapath.
package maxpool_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int NUM_REQ_DEF     = 4;
  localparam int DATA_WIDTH_DEF  = 19;
  localparam int INPUT_NODE_DEF  = 100;
  localparam int OUTPUT_NODE_DEF = 25;
endpackage

// File: rtl/maxpool_rr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; first set request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
)(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    // ptr itself is visited last, so the previous winner has lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/maxpool_rr_sched.sv
// maxpool_rr_sched: round-robin sharing of one 2x2 max-pool datapath among NUM_REQ map producers.
// Optional datapath-response watchdog enabled by defining MAXPOOL_WDOG_EN.
module maxpool_rr_sched
  import maxpool_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INPUT_NODE  = INPUT_NODE_DEF,
  parameter int OUTPUT_NODE = OUTPUT_NODE_DEF,
  parameter int ID_W        = $clog2(NUM_REQ)
`ifdef MAXPOOL_WDOG_EN
  , parameter int TIMEOUT   = 15
`endif
)(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ*DATA_WIDTH*INPUT_NODE-1:0]   req_data,
  output logic [NUM_REQ-1:0]                         req_ack,
  output logic [DATA_WIDTH*INPUT_NODE-1:0]           pool_in,
  output logic                                       pool_valid,
  input  logic                                       pool_ready,
  input  logic [DATA_WIDTH*OUTPUT_NODE-1:0]          pool_out,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_WIDTH*OUTPUT_NODE-1:0]          out_data,
  output logic [ID_W-1:0]                            out_id,
  output logic [15:0]                                out_cnt,
  output logic                                       err
);
  localparam int MAP_W = DATA_WIDTH * INPUT_NODE;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, gnt_id;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [MAP_W-1:0]   in_reg;
  logic               take, capture, retire;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req  (req_valid),
    .ptr  (ptr),
    .grant(gnt),
    .id   (gnt_id),
    .any  (gnt_any)
  );

`ifdef MAXPOOL_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_trip;

  assign wd_trip = (state == WAIT) && !pool_ready && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != WAIT)   wd_cnt <= '0;
      else if (!pool_ready) wd_cnt <= wd_cnt + 1'b1;
      if (wd_trip) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE:  if (gnt_any) begin take = 1'b1; state_nxt = ISSUE; end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (pool_ready) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
`ifdef MAXPOOL_WDOG_EN
        else if (wd_trip) state_nxt = IDLE;
`endif
      end
      HOLD:  if (out_ready) begin retire = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Ack is the grant itself; masked during reset so nothing is acknowledged then.
  assign req_ack    = (take && !rst) ? gnt : '0;
  assign pool_valid = (state == ISSUE);
  assign pool_in    = in_reg;

  // ptr doubles as the id of the in-flight map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= ID_W'(NUM_REQ - 1);
      in_reg    <= '0;
      out_data  <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (take) begin
        in_reg <= req_data[int'(gnt_id)*MAP_W +: MAP_W];
        ptr    <= gnt_id;
      end
      if (capture) begin
        out_data  <= pool_out;
        out_id    <= ptr;
        out_valid <= 1'b1;
      end
      if (retire) begin
        out_valid <= 1'b0;
        out_cnt   <= out_cnt + 16'd1;
      end
    end
  end
endmodule
